// File: rtl/hash_mem_responder.sv
// Word-addressed memory responder for the hash core: host preload/readback around a
// core run, with core write counting, a run watchdog and out-of-range tracking.
module hash_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int NUM_RESULTS = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        host_we,
  input  logic        host_re,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  output logic        host_busy,
  output logic        core_start,
  input  logic        core_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        run_done,
  output logic        timeout,
  output logic        oob_err,
  output logic [7:0]  wr_count,
  output logic        wr_full
);
  localparam int          DEPTH      = 1 << ADDR_BITS;
  localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);
  localparam logic [8:0]  FULL_LEVEL = 9'(NUM_RESULTS);

  typedef enum logic [1:0] {LOAD, START, RUN, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] cycle_cnt;
  logic [31:0] ram [DEPTH];

  logic                 host_ok;
  logic                 host_in_range;
  logic                 core_in_range;
  logic                 host_wr;
  logic                 core_wr;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_waddr;
  logic [31:0]          ram_wdata;

  assign host_ok       = (state == LOAD) || (state == DONE);
  assign host_in_range = (host_addr >> ADDR_BITS) == 16'd0;
  assign core_in_range = (mem_addr >> ADDR_BITS) == 16'd0;

  // Host and core never own the memory in the same state, so one write port suffices.
  assign host_wr   = !reset && host_ok && host_we && host_in_range;
  assign core_wr   = !reset && (state == RUN) && mem_we && core_in_range;
  assign ram_we    = host_wr || core_wr;
  assign ram_waddr = core_wr ? mem_addr[ADDR_BITS-1:0] : host_addr[ADDR_BITS-1:0];
  assign ram_wdata = core_wr ? mem_write_data : host_wdata;

  assign wr_full = {1'b0, wr_count} >= FULL_LEVEL;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (go) next_state = START;
      START:   next_state = RUN;
      RUN:     if (core_done || cycle_cnt == LAST_CYCLE) next_state = DONE;
      DONE:    if (go) next_state = START;
      default: next_state = LOAD;
    endcase
  end

  // NOTE: the array has no reset; results must survive a reset that abandons a run.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOAD;
      cycle_cnt     <= '0;
      core_start    <= 1'b0;
      host_busy     <= 1'b0;
      run_done      <= 1'b0;
      host_rvalid   <= 1'b0;
      host_rdata    <= '0;
      mem_read_data <= '0;
      timeout       <= 1'b0;
      oob_err       <= 1'b0;
      wr_count      <= '0;
    end else begin
      state       <= next_state;
      core_start  <= (next_state == START);
      host_busy   <= (next_state == START) || (next_state == RUN);
      run_done    <= (next_state == DONE);
      host_rvalid <= host_ok && host_re;

      if (host_ok && host_re)
        host_rdata <= host_in_range ? ram[host_addr[ADDR_BITS-1:0]] : 32'd0;
      if (host_ok && (host_we || host_re) && !host_in_range)
        oob_err <= 1'b1;

      if (state == START)
        cycle_cnt <= '0;

      if (state == RUN) begin
        cycle_cnt     <= cycle_cnt + 16'd1;
        mem_read_data <= core_in_range ? ram[mem_addr[ADDR_BITS-1:0]] : 32'd0;
        if (!core_in_range)
          oob_err <= 1'b1;
        if (core_wr && wr_count != 8'hFF)
          wr_count <= wr_count + 8'd1;
        // A core_done arriving on the last watchdog cycle is a normal completion.
        if (cycle_cnt == LAST_CYCLE && !core_done)
          timeout <= 1'b1;
      end

      // Starting a run wipes the per-run status; placed last so it takes priority.
      if (next_state == START) begin
        wr_count <= '0;
        timeout  <= 1'b0;
        oob_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hash_mem_responder.sv
// Self-checking bench for hash_mem_responder: random host/core traffic compared against
// an array model of the memory and the run-level rules of the responder.
module tb_hash_mem_responder;
  localparam int TO   = 32;
  localparam int NRES = 16;

  logic        clk = 1'b0;
  logic        reset, go, host_we, host_re, core_done, mem_we;
  logic [15:0] host_addr, mem_addr;
  logic [31:0] host_wdata, mem_write_data;
  logic [31:0] host_rdata, mem_read_data;
  logic        host_rvalid, host_busy, core_start, run_done, timeout, oob_err, wr_full;
  logic [7:0]  wr_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [256];

  hash_mem_responder #(.ADDR_BITS(8), .NUM_RESULTS(NRES), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go),
    .host_we(host_we), .host_re(host_re), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_busy(host_busy),
    .core_start(core_start), .core_done(core_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .run_done(run_done), .timeout(timeout),
    .oob_err(oob_err), .wr_count(wr_count), .wr_full(wr_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] a, output logic [31:0] d, output logic v);
    host_re = 1'b1; host_addr = a;
    step();
    d = host_rdata; v = host_rvalid;
    host_re = 1'b0;
  endtask

  task automatic start_run();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 0; host_we = 0; host_re = 0; core_done = 0; mem_we = 0;
    host_addr = 0; mem_addr = 0; host_wdata = 0; mem_write_data = 0;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({core_start, host_busy, run_done, timeout, oob_err, host_rvalid, wr_full} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000000",
               {core_start, host_busy, run_done, timeout, oob_err, host_rvalid, wr_full});
    end
    checks++;
    if (wr_count !== 8'd0) begin
      errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count);
    end
    checks++;
    if ({host_rdata, mem_read_data} !== 64'd0) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0/0", host_rdata, mem_read_data);
    end
  endtask

  task automatic test_host_load();
    logic [31:0] d, nd;
    logic        v;
    logic [15:0] a;
    for (int i = 0; i < 20; i++) begin
      host_write(16'(i), 32'h1000 + i);
      model_mem[i] = 32'h1000 + i;
    end
    for (int i = 20; i < 256; i++) begin
      d = $urandom;
      host_write(16'(i), d);
      model_mem[i] = d;
    end
    host_read(16'd5, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h1005) begin
      errors++; $display("FAIL host_rd_5 got v=%b %h exp v=1 00001005", v, d);
    end
    step();
    checks++;
    if (host_rvalid !== 1'b0) begin
      errors++; $display("FAIL host_rvalid_drop got %b exp 0", host_rvalid);
    end
    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom_range(0, 255));
      host_read(a, d, v);
      checks++;
      if (v !== 1'b1 || d !== model_mem[a]) begin
        errors++; $display("FAIL host_rd_rand addr %h got %h exp %h", a, d, model_mem[a]);
      end
    end
    // simultaneous write and read of one address returns the old word
    a = 16'($urandom_range(20, 255));
    nd = $urandom;
    host_we = 1'b1; host_re = 1'b1; host_addr = a; host_wdata = nd;
    step();
    host_we = 1'b0; host_re = 1'b0;
    checks++;
    if (host_rdata !== model_mem[a]) begin
      errors++; $display("FAIL host_we_re_old got %h exp %h", host_rdata, model_mem[a]);
    end
    model_mem[a] = nd;
    host_read(a, d, v);
    checks++;
    if (d !== nd) begin
      errors++; $display("FAIL host_we_re_new got %h exp %h", d, nd);
    end
    // out-of-range host accesses: write dropped, read gives zero and flags oob
    host_write(16'h0100, 32'hBAD0_0000);
    host_read(16'h0100, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'd0 || oob_err !== 1'b1) begin
      errors++; $display("FAIL host_oob_rd got v=%b %h oob=%b exp v=1 0 oob=1", v, d, oob_err);
    end
  endtask

  task automatic test_core_read();
    logic [31:0] d;
    logic        v;
    start_run();
    checks++;
    if ({core_start, host_busy, run_done, oob_err} !== 4'b1100) begin
      errors++;
      $display("FAIL start_state got %b exp 1100", {core_start, host_busy, run_done, oob_err});
    end
    mem_addr = 16'd0;
    step();
    checks++;
    if ({core_start, host_busy} !== 2'b01) begin
      errors++; $display("FAIL run_entry got %b exp 01", {core_start, host_busy});
    end
    for (int a = 0; a < 20; a++) begin
      mem_addr = 16'(a);
      step();
      checks++;
      if (mem_read_data !== 32'h1000 + a) begin
        errors++; $display("FAIL core_rd addr %0d got %h exp %h", a, mem_read_data, 32'h1000 + a);
      end
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if ({run_done, host_busy, timeout} !== 3'b100 || wr_count !== 8'd0) begin
      errors++;
      $display("FAIL core_rd_done got %b cnt %0d exp 100 cnt 0", {run_done, host_busy, timeout}, wr_count);
    end
    // core traffic outside RUN is ignored and the read register holds
    mem_we = 1'b1; mem_addr = 16'd7; mem_write_data = 32'hFFFF_FFFF;
    step(); step();
    mem_we = 1'b0; mem_addr = 16'd0;
    checks++;
    if (mem_read_data !== model_mem[19] || wr_count !== 8'd0) begin
      errors++;
      $display("FAIL core_idle got %h cnt %0d exp %h cnt 0", mem_read_data, wr_count, model_mem[19]);
    end
    host_read(16'd7, d, v);
    checks++;
    if (d !== model_mem[7]) begin
      errors++; $display("FAIL core_idle_wr got %h exp %h", d, model_mem[7]);
    end
  endtask

  task automatic test_core_write();
    logic [31:0] d;
    logic        v;
    int          a;
    start_run();
    step();
    for (int i = 0; i < 16; i++) begin
      a = 'h40 + i;
      d = $urandom;
      mem_we = 1'b1; mem_addr = 16'(a); mem_write_data = d;
      go = (i == 3);
      core_done = (i == 15);
      step();
      checks++;
      if (mem_read_data !== model_mem[a]) begin
        errors++; $display("FAIL core_wr_old addr %h got %h exp %h", a, mem_read_data, model_mem[a]);
      end
      model_mem[a] = d;
      checks++;
      if (wr_count !== 8'(i + 1) || wr_full !== (i + 1 >= NRES) || core_start !== 1'b0) begin
        errors++;
        $display("FAIL core_wr_cnt step %0d got cnt %0d full %b start %b exp cnt %0d full %b start 0",
                 i, wr_count, wr_full, core_start, i + 1, (i + 1 >= NRES));
      end
    end
    mem_we = 1'b0; core_done = 1'b0; go = 1'b0; mem_addr = 16'd0;
    checks++;
    if (run_done !== 1'b1 || wr_count !== 8'd16 || wr_full !== 1'b1) begin
      errors++;
      $display("FAIL core_wr_done got done %b cnt %0d full %b exp 1 16 1", run_done, wr_count, wr_full);
    end
    host_read(16'h004F, d, v);
    checks++;
    if (v !== 1'b1 || d !== model_mem['h4F]) begin
      errors++; $display("FAIL host_rd_4f got %h exp %h", d, model_mem['h4F]);
    end
  endtask

  task automatic test_busy_oob();
    logic [31:0] d;
    logic        v;
    start_run();
    step();
    host_we = 1'b1; host_re = 1'b1; host_addr = 16'd0; host_wdata = 32'hDEAD_BEEF;
    mem_we = 1'b1; mem_addr = 16'h0100; mem_write_data = $urandom;
    step();
    host_we = 1'b0; host_re = 1'b0; mem_we = 1'b0; mem_addr = 16'h0020;
    checks++;
    if ({host_busy, host_rvalid, oob_err} !== 3'b101 || mem_read_data !== 32'd0 || wr_count !== 8'd0) begin
      errors++;
      $display("FAIL busy_oob got busy %b rv %b oob %b rd %h cnt %0d exp 1 0 1 0 0",
               host_busy, host_rvalid, oob_err, mem_read_data, wr_count);
    end
    d = $urandom;
    mem_we = 1'b1; mem_addr = 16'h0021; mem_write_data = d;
    step();
    model_mem['h21] = d;
    mem_we = 1'b0;
    checks++;
    if (wr_count !== 8'd1) begin
      errors++; $display("FAIL busy_inrange_cnt got %0d exp 1", wr_count);
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0; mem_addr = 16'd0;
    checks++;
    if (run_done !== 1'b1 || oob_err !== 1'b1) begin
      errors++; $display("FAIL oob_sticky got done %b oob %b exp 1 1", run_done, oob_err);
    end
    host_read(16'd0, d, v);
    checks++;
    if (d !== 32'h1000) begin
      errors++; $display("FAIL busy_ram0 got %h exp 00001000", d);
    end
    host_read(16'h0021, d, v);
    checks++;
    if (d !== model_mem['h21]) begin
      errors++; $display("FAIL busy_ram21 got %h exp %h", d, model_mem['h21]);
    end
  endtask

  task automatic test_timeout();
    int n;
    start_run();
    checks++;
    if (oob_err !== 1'b0 || wr_count !== 8'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL go_clears got oob %b cnt %0d to %b exp 0 0 0", oob_err, wr_count, timeout);
    end
    mem_addr = 16'd0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (run_done) break;
      n++;
    end
    checks++;
    if (run_done !== 1'b1 || n !== TO || timeout !== 1'b1) begin
      errors++;
      $display("FAIL watchdog got done %b run_cycles %0d to %b exp 1 %0d 1", run_done, n, timeout, TO);
    end
    start_run();
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL go_clears_to got %b exp 0", timeout);
    end
    for (int k = 0; k < TO; k++) step();
    checks++;
    if (run_done !== 1'b0) begin
      errors++; $display("FAIL watchdog_early got %b exp 0", run_done);
    end
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    checks++;
    if (run_done !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL done_beats_to got done %b to %b exp 1 0", run_done, timeout);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        v;
    int          a, nops, exp_cnt, we;
    for (int r = 0; r < 4; r++) begin
      start_run();
      step();
      nops = $urandom_range(4, 20);
      exp_cnt = 0;
      for (int k = 0; k < nops; k++) begin
        a = $urandom_range(0, 255);
        we = $urandom_range(0, 1);
        d = $urandom;
        mem_addr = 16'(a); mem_we = we[0]; mem_write_data = d;
        core_done = (k == nops - 1);
        step();
        checks++;
        if (mem_read_data !== model_mem[a]) begin
          errors++; $display("FAIL b2b_rd run %0d addr %h got %h exp %h", r, a, mem_read_data, model_mem[a]);
        end
        if (we != 0) begin
          model_mem[a] = d;
          exp_cnt++;
        end
      end
      mem_we = 1'b0; core_done = 1'b0; mem_addr = 16'd0;
      checks++;
      if (run_done !== 1'b1 || wr_count !== 8'(exp_cnt) || wr_full !== (exp_cnt >= NRES)) begin
        errors++;
        $display("FAIL b2b_done run %0d got done %b cnt %0d exp 1 %0d", r, run_done, wr_count, exp_cnt);
      end
      for (int k = 0; k < 3; k++) begin
        a = $urandom_range(0, 255);
        host_read(16'(a), d, v);
        checks++;
        if (v !== 1'b1 || d !== model_mem[a]) begin
          errors++; $display("FAIL b2b_host addr %h got %h exp %h", a, d, model_mem[a]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    logic        v;
    start_run();
    step();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      mem_we = 1'b1; mem_addr = 16'('h80 + i); mem_write_data = d;
      step();
      model_mem['h80 + i] = d;
    end
    mem_we = 1'b0; mem_addr = 16'd0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({core_start, run_done, host_busy} !== 3'b000 || wr_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset got %b cnt %0d exp 000 cnt 0", {core_start, run_done, host_busy}, wr_count);
    end
    for (int i = 0; i < 4; i++) begin
      host_read(16'('h80 + i), d, v);
      checks++;
      if (v !== 1'b1 || d !== model_mem['h80 + i]) begin
        errors++; $display("FAIL mid_reset_keep addr %h got %h exp %h", 'h80 + i, d, model_mem['h80 + i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_host_load();
    test_core_read();
    test_core_write();
    test_busy_oob();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
